// File: rtl/dense_stream_mac.sv
// dense_stream_mac: one fully-connected layer, y[j] = sat(round(sum_i x[i]*W[i][j] + b[j])).
// Input elements stream in serially; N_OUT MAC lanes each take one product per element.
// Coefficients (weights, then biases) are loaded at runtime through the coef_* port.
// Build option: define DENSE_STREAM_MAC_RELU_EN to clamp negative results to 0 in the
// output register (fused ReLU). The default build emits the signed saturated value.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1.
// valid never depends on ready; once out_valid is high, out_data is held until the transfer.
// in_ready is low while coef_we is high, so a coefficient write always beats an element.
module dense_stream_mac #(
    parameter  int N_IN  = 32,
    parameter  int N_OUT = 5,
    parameter  int WIDTH = 23,
    parameter  int NFRAC = 11,
    localparam int ACC_W = 2*WIDTH + $clog2(N_IN) + 1,
    localparam int AW    = $clog2(N_IN*N_OUT + N_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic [WIDTH-1:0]         coef_data,
    output logic                     coef_err,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT*WIDTH-1:0]   out_data
);

    localparam int NW    = N_IN * N_OUT;          // first bias address
    localparam int NCOEF = N_IN * N_OUT + N_OUT;  // total coefficient words
    localparam int CW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam int SW    = ACC_W + 2;             // room for bias and rounding constant

    localparam logic signed [SW-1:0] YMAX = SW'((longint'(1) <<< (WIDTH-1)) - 1);
    localparam logic signed [SW-1:0] YMIN = ~YMAX;
    localparam logic [SW-1:0]        HALF = SW'(1) << (NFRAC-1);

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    // state is kept as a plain named signal so checkers can bind to it
    state_t                   state, state_nx;
    logic                     drain_ph;   // 0: fold last products, 1: round into out_data
    logic                     rdy_en;     // holds in_ready low until the first cycle after reset
    logic [CW-1:0]            cnt;
    logic signed [WIDTH-1:0]  coef [NCOEF];
    logic signed [WIDTH-1:0]  wsel [N_OUT];
    logic signed [PW-1:0]     prod [N_OUT];
    logic                     prod_vld;
    logic signed [ACC_W-1:0]  acc  [N_OUT];
    logic signed [WIDTH-1:0]  ysat [N_OUT];
    logic signed [WIDTH-1:0]  bias_w;
    logic signed [SW-1:0]     s_w;
    logic signed [SW-1:0]     y_w;

    logic fire, out_hs, last_elem, coef_ok, load_out;

    assign fire      = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign last_elem = (cnt == CW'(N_IN - 1));
    assign coef_ok   = coef_we && (state == S_ACC) && (cnt == '0) && (int'(coef_addr) < NCOEF);
    assign load_out  = (state == S_DRAIN) && drain_ph;

    // state register, including the two-cycle drain phase bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_ACC;
            drain_ph <= 1'b0;
        end else begin
            state    <= state_nx;
            drain_ph <= (state == S_DRAIN) ? ~drain_ph : 1'b0;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_ACC:   if (fire && last_elem) state_nx = S_DRAIN;
            S_DRAIN: if (drain_ph)          state_nx = S_OUT;
            S_OUT:   if (out_hs)            state_nx = S_ACC;
            default:                        state_nx = S_ACC;
        endcase
    end

    // FSM outputs: accept elements only while accumulating and no write is pending
    always_comb begin
        in_ready = rdy_en && (state == S_ACC) && !coef_we;
    end

    // coefficient store and sticky error flag for rejected writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCOEF; k++) coef[k] <= '0;
            coef_err <= 1'b0;
        end else begin
            if (coef_ok) coef[coef_addr] <= coef_data;
            if (coef_we && !coef_ok) coef_err <= 1'b1;
        end
    end

    // weight row for the element currently presented
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            wsel[j] = coef[AW'(int'(cnt) * N_OUT + j)];
        end
    end

    // element counter, product registers and full-precision accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            cnt      <= '0;
            prod_vld <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                prod[j] <= '0;
                acc[j]  <= '0;
            end
        end else begin
            rdy_en   <= 1'b1;
            prod_vld <= fire;
            if (fire) cnt <= last_elem ? '0 : cnt + CW'(1);
            for (int j = 0; j < N_OUT; j++) begin
                if (fire) prod[j] <= PW'($signed(in_data)) * PW'(wsel[j]);
                if (out_hs)        acc[j] <= '0;
                else if (prod_vld) acc[j] <= acc[j] + ACC_W'(prod[j]);
            end
        end
    end

    // bias add, round half toward +inf, saturate (and optional ReLU) per lane
    always_comb begin
        bias_w = '0;
        s_w    = '0;
        y_w    = '0;
        for (int j = 0; j < N_OUT; j++) begin
            bias_w = coef[AW'(NW + j)];
            s_w = {{(SW-ACC_W){acc[j][ACC_W-1]}}, acc[j]}
                + ({{(SW-WIDTH){bias_w[WIDTH-1]}}, bias_w} <<< NFRAC)
                + HALF;
            y_w = s_w >>> NFRAC;
            if (y_w > YMAX)      ysat[j] = WIDTH'(YMAX);
            else if (y_w < YMIN) ysat[j] = WIDTH'(YMIN);
            else                 ysat[j] = WIDTH'(y_w);
`ifdef DENSE_STREAM_MAC_RELU_EN
            if (ysat[j][WIDTH-1]) ysat[j] = '0;
`endif
        end
    end

    // result register: loaded on the second drain cycle, held until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            for (int j = 0; j < N_OUT; j++) out_data[j*WIDTH +: WIDTH] <= ysat[j];
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dense_stream_mac.sv
// tb_dense_stream_mac: directed table of layer vectors plus randomized frames checked
// against an arithmetic model of the layer (sum of products, bias, floor-round, clamp).
module tb_dense_stream_mac;

  localparam int N_IN  = 32;
  localparam int N_OUT = 5;
  localparam int WIDTH = 23;
  localparam int NFRAC = 11;
  localparam int NW    = N_IN * N_OUT;
  localparam int NCOEF = N_IN * N_OUT + N_OUT;
  localparam int AW    = $clog2(NCOEF);
  localparam int OW    = N_OUT * WIDTH;
`ifdef DENSE_STREAM_MAC_RELU_EN
  localparam int SNEG = 0;
`else
  localparam int SNEG = -4194304;
`endif

  logic             clk;
  logic             rst_n;
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [WIDTH-1:0] coef_data;
  logic             coef_err;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OW-1:0]    out_data;

  dense_stream_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .NFRAC(NFRAC)) dut (
    .clk(clk), .rst_n(rst_n),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- model state and scoreboard ----------------
  int w_m [N_IN][N_OUT];
  int b_m [N_OUT];
  int x_vec [N_IN];
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string name;
    int    w_diag;
    int    w_off;
    int    b [N_OUT];
    int    x0;
    int    x_base;
    int    x_step;
    bit    gaps;
    int    exp [N_OUT];
  } vec_t;
  vec_t tbl [7];

  task automatic check_int(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // y[j] = clamp(floor((sum_i x[i]*W[i][j] + b[j]*2^NFRAC + 2^(NFRAC-1)) / 2^NFRAC))
  function automatic logic [OW-1:0] model_frame();
    logic [OW-1:0] v;
    longint s, y, hi, lo;
    v  = '0;
    hi = (longint'(1) <<< (WIDTH-1)) - 1;
    lo = -hi - 1;
    for (int j = 0; j < N_OUT; j++) begin
      s = longint'(b_m[j]) * (longint'(1) <<< NFRAC);
      for (int i = 0; i < N_IN; i++) s += longint'(x_vec[i]) * longint'(w_m[i][j]);
      s += longint'(1) <<< (NFRAC-1);
      y = s >>> NFRAC;
      if (y > hi) y = hi;
      if (y < lo) y = lo;
`ifdef DENSE_STREAM_MAC_RELU_EN
      if (y < 0) y = 0;
`endif
      v[j*WIDTH +: WIDTH] = WIDTH'(y);
    end
    return v;
  endfunction

  function automatic int rnd(input int span);
    return int'($urandom_range(0, 2*span)) - span;
  endfunction

  task automatic randomize_coefs();
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) w_m[i][j] = rnd(4096);
    for (int j = 0; j < N_OUT; j++) b_m[j] = rnd(1 << 20);
  endtask

  task automatic randomize_x();
    for (int i = 0; i < N_IN; i++) x_vec[i] = rnd(1 << 14);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) w_m[i][j] = 0;
    for (int j = 0; j < N_OUT; j++) b_m[j] = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_all();
    for (int a = 0; a < NCOEF; a++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      coef_we   = 1'b1;
      coef_addr = AW'(a);
      coef_data = (a < NW) ? WIDTH'(w_m[a / N_OUT][a % N_OUT]) : WIDTH'(b_m[a - NW]);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic write_one(input int addr, input int data);
    @(negedge clk);
    in_valid  = 1'b0;
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = WIDTH'(data);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send_elems(input int first, input int last, input bit gaps);
    int i;
    int guard;
    i = first;
    guard = 0;
    while (i <= last && guard < 1000) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = WIDTH'(x_vec[i]);
      end
      #1;
      if (in_valid && in_ready) i++;
      guard++;
    end
    check_int("elements_accepted", i, last + 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat++;
    end while (!out_valid && lat < 60);
    check_int("out_valid_seen", out_valid, 1);
  endtask

  task automatic release_out();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check_int("out_valid_after_take", out_valid, 0);
    check_int("in_ready_after_take", in_ready, 1);
  endtask

  task automatic run_frame(input string name, input bit gaps);
    int lat;
    exp_q.push_back(model_frame());
    send_elems(0, N_IN-1, gaps);
    wait_out(lat);
    check_int({name, "_latency"}, lat, 3);
    check_vec({name, "_data"}, out_data, exp_q.pop_front());
    release_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_int("rst_in_ready", in_ready, 0);
    check_int("rst_out_valid", out_valid, 0);
    check_vec("rst_out_data", out_data, '0);
    check_int("rst_coef_err", coef_err, 0);
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_int("in_ready_after_reset", in_ready, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    logic [OW-1:0] texp, held;

    tbl[0] = '{"identity",   2048, 0, '{0, 0, 0, 0, 0},          0,     0,    2048, 1'b0,
               '{0, 2048, 4096, 6144, 8192}};
    tbl[1] = '{"bias_round", 1,    0, '{-127, 100, 200, -300, 400}, 1024, 0,    0,    1'b1,
               '{-126, 100, 200, -300, 400}};
    tbl[2] = '{"round_neg_half", 1, 0, '{0, 0, 0, 0, 0},         -1024, 0,    0,    1'b0,
               '{0, 0, 0, 0, 0}};
    tbl[3] = '{"round_below", 1,   0, '{0, 0, 0, 0, 0},          -1025, 0,    0,    1'b1,
               '{-1, 0, 0, 0, 0}};
    tbl[4] = '{"round_pos_half", 1, 0, '{0, 0, 0, 0, 0},          3072, 0,    0,    1'b0,
               '{2, 0, 0, 0, 0}};
    tbl[5] = '{"sat_pos", 4194303, 4194303, '{0, 0, 0, 0, 0},  4194303, 4194303, 0, 1'b1,
               '{4194303, 4194303, 4194303, 4194303, 4194303}};
    tbl[6] = '{"sat_neg", 4194303, 4194303, '{0, 0, 0, 0, 0}, -4194303, -4194303, 0, 1'b0,
               '{SNEG, SNEG, SNEG, SNEG, SNEG}};

    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    clear_model();
    do_reset();

    // directed table
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < N_IN; i++) begin
        for (int j = 0; j < N_OUT; j++) w_m[i][j] = (i == j) ? tbl[r].w_diag : tbl[r].w_off;
        x_vec[i] = (i == 0) ? tbl[r].x0 : tbl[r].x_base + i * tbl[r].x_step;
      end
      for (int j = 0; j < N_OUT; j++) b_m[j] = tbl[r].b[j];
      texp = '0;
      for (int j = 0; j < N_OUT; j++) texp[j*WIDTH +: WIDTH] = WIDTH'(tbl[r].exp[j]);
      write_all();
      exp_q.push_back(model_frame());
      send_elems(0, N_IN-1, tbl[r].gaps);
      wait_out(lat);
      check_int($sformatf("%s_latency", tbl[r].name), lat, 3);
      check_vec($sformatf("%s_table", tbl[r].name), out_data, texp);
      check_vec($sformatf("%s_model", tbl[r].name), out_data, exp_q.pop_front());
      release_out();
    end
    check_int("coef_err_after_table", coef_err, 0);

    // write colliding with in_valid, then backpressure on the result
    randomize_coefs();
    randomize_x();
    write_all();
    @(negedge clk);
    w_m[0][3]  = rnd(4096);
    coef_we    = 1'b1;
    coef_addr  = AW'(3);
    coef_data  = WIDTH'(w_m[0][3]);
    in_valid   = 1'b1;
    in_data    = WIDTH'(12345);
    #1;
    check_int("collide_in_ready", in_ready, 0);
    @(negedge clk);
    coef_we  = 1'b0;
    in_valid = 1'b0;
    exp_q.push_back(model_frame());
    send_elems(0, N_IN-1, 1'b1);
    wait_out(lat);
    check_int("bp_latency", lat, 3);
    held = out_data;
    check_vec("bp_data", held, exp_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      #1;
      check_vec($sformatf("bp_hold_data_%0d", k), out_data, held);
      check_int($sformatf("bp_hold_in_ready_%0d", k), in_ready, 0);
      check_int($sformatf("bp_hold_valid_%0d", k), out_valid, 1);
    end
    release_out();
    randomize_x();
    out_ready = 1'b1;
    run_frame("bp_second", 1'b1);
    check_int("coef_err_after_bp", coef_err, 0);

    // rejected writes mid-frame and while the result is pending
    randomize_coefs();
    randomize_x();
    write_all();
    exp_q.push_back(model_frame());
    send_elems(0, 6, 1'b1);
    write_one(0, w_m[0][0] + 77);
    #1;
    check_int("midframe_coef_err", coef_err, 1);
    send_elems(7, N_IN-1, 1'b1);
    wait_out(lat);
    check_int("midframe_latency", lat, 3);
    check_vec("midframe_data", out_data, exp_q.pop_front());
    write_one(NW + 1, b_m[1] + 5000);
    release_out();
    randomize_x();
    run_frame("after_out_write", 1'b0);

    // reset mid-frame: coefficients and partial sums are discarded
    randomize_coefs();
    randomize_x();
    write_all();
    send_elems(0, 14, 1'b0);
    do_reset();
    randomize_x();
    run_frame("cleared_coefs", 1'b0);
    randomize_coefs();
    randomize_x();
    write_all();
    run_frame("after_reload", 1'b1);

    // out-of-range addresses at an otherwise legal time
    check_int("err_before_range", coef_err, 0);
    write_one(NCOEF, 999);
    #1;
    check_int("range_first_err", coef_err, 1);
    write_one(200, -999);
    randomize_x();
    run_frame("after_range", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
